trap_ctrl: RTL and testbench

Machine-mode trap sequencer sitting directly downstream of `csrfile`. It consumes `csrfile`'s pending-interrupt vector, global interrupt enable, privilege, `mtvec` and `mepc`. It arbitrates commit-time exceptions, interrupts, MRET and WFI, holds commit and drains the backend. It then pulses `take_exception`, `take_interrupt` or `mret` into `csrfile` together with epc, cause and tval, and redirects the frontend.

---
 rtl/trap_pkg.sv | 39 +++
 rtl/trap_irq_select.sv | 23 ++
 rtl/trap_ctrl.sv | 171 +++++++++++++++++
 tb/tb_trap_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
// Holds the FSM state and event-kind encodings, cause codes and the redirect target helper.
package trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ISSUE = 2'd2,
        ST_SLEEP = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        KIND_EXC = 2'd0,
        KIND_IRQ = 2'd1,
        KIND_RET = 2'd2
    } kind_t;

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_MSI     = 4'd3;
    localparam logic [3:0] CAUSE_MTI     = 4'd7;
    localparam logic [3:0] CAUSE_MEI     = 4'd11;

    // Only interrupts honour vectored mode; the 30-bit sum wraps.
    function automatic logic [29:0] trap_target(
        input kind_t       kind,
        input logic [31:0] mtvec,
        input logic [29:0] mepc,
        input logic [3:0]  cause
    );
        logic [29:0] base;
        base = mtvec[31:2];
        case (kind)
            KIND_IRQ: trap_target = (mtvec[1:0] == 2'b01) ? base + {26'd0, cause} : base;
            KIND_RET: trap_target = mepc;
            default:  trap_target = base;
        endcase
    endfunction

endpackage

// File: rtl/trap_irq_select.sv
// Fixed-priority interrupt selector: MEI > MSI > MTI.
// The pending vector is packed {MEI, MTI, MSI}.
module trap_irq_select
    import trap_pkg::*;
(
    input  logic [2:0] mip,
    output logic       valid,
    output logic [3:0] cause
);

    always_comb begin
        valid = |mip;
        cause = 4'd0;
        if (mip[2]) begin
            cause = CAUSE_MEI;
        end else if (mip[0]) begin
            cause = CAUSE_MSI;
        end else if (mip[1]) begin
            cause = CAUSE_MTI;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exceptions, interrupts, MRET and WFI,
// drains the backend, then pulses the chosen trap into csrfile and redirects fetch.
module trap_ctrl
    import trap_pkg::*;
(
    input  logic        cpu_clock_i,
    input  logic        cpu_reset_i,
    input  logic        excp_valid_i,
    input  logic [3:0]  excp_code_i,
    input  logic [29:0] excp_pc_i,
    input  logic [31:0] excp_tval_i,
    input  logic        mret_valid_i,
    input  logic        wfi_valid_i,
    input  logic [29:0] commit_pc_i,
    input  logic [2:0]  csrfile_mip_o,
    input  logic        mie_o,
    input  logic        real_privilege,
    input  logic [31:0] mtvec_o,
    input  logic [29:0] mepc_o,
    output logic        commit_hold_o,
    output logic        flush_o,
    input  logic        flush_done_i,
    output logic        take_exception,
    output logic        take_interrupt,
    output logic        mret,
    output logic [29:0] csrfile_epc_i,
    output logic [31:0] csrfile_mtval_i,
    output logic [3:0]  csrfile_mcause_i,
    output logic        redirect_valid_o,
    output logic [29:0] redirect_pc_o
);

    state_t      state, state_nxt;
    kind_t       kind, kind_nxt;
    logic [3:0]  cause_nxt;
    logic [29:0] epc_nxt;
    logic [31:0] tval_nxt;
    logic        hold_nxt, flush_nxt;
    logic        take_exc_nxt, take_irq_nxt, mret_nxt;
    logic        redir_vld_nxt;
    logic [29:0] redir_pc_nxt;

    logic        irq_valid;
    logic [3:0]  irq_cause;
    logic        irq_take;

    trap_irq_select u_irq_select (
        .mip   (csrfile_mip_o),
        .valid (irq_valid),
        .cause (irq_cause)
    );

    // U-mode is always interruptible by M-level sources.
    assign irq_take = irq_valid && (mie_o || !real_privilege);

    always_comb begin
        state_nxt     = state;
        kind_nxt      = kind;
        cause_nxt     = csrfile_mcause_i;
        epc_nxt       = csrfile_epc_i;
        tval_nxt      = csrfile_mtval_i;
        flush_nxt     = 1'b0;
        take_exc_nxt  = 1'b0;
        take_irq_nxt  = 1'b0;
        mret_nxt      = 1'b0;
        redir_vld_nxt = 1'b0;
        redir_pc_nxt  = '0;

        case (state)
            ST_IDLE: begin
                if (excp_valid_i) begin
                    state_nxt = ST_DRAIN;
                    flush_nxt = 1'b1;
                    kind_nxt  = KIND_EXC;
                    cause_nxt = excp_code_i;
                    epc_nxt   = excp_pc_i;
                    tval_nxt  = excp_tval_i;
                end else if (irq_take) begin
                    state_nxt = ST_DRAIN;
                    flush_nxt = 1'b1;
                    kind_nxt  = KIND_IRQ;
                    cause_nxt = irq_cause;
                    epc_nxt   = commit_pc_i;
                    tval_nxt  = '0;
                end else if (mret_valid_i) begin
                    state_nxt = ST_DRAIN;
                    flush_nxt = 1'b1;
                    if (real_privilege) begin
                        kind_nxt = KIND_RET;
                    end else begin
                        // MRET from U-mode traps as an illegal instruction at its own PC.
                        kind_nxt  = KIND_EXC;
                        cause_nxt = CAUSE_ILLEGAL;
                        epc_nxt   = commit_pc_i;
                        tval_nxt  = '0;
                    end
                end else if (wfi_valid_i) begin
                    state_nxt = ST_SLEEP;
                end
            end

            ST_DRAIN: begin
                if (flush_done_i) begin
                    state_nxt     = ST_ISSUE;
                    take_exc_nxt  = (kind == KIND_EXC);
                    take_irq_nxt  = (kind == KIND_IRQ);
                    mret_nxt      = (kind == KIND_RET);
                    redir_vld_nxt = 1'b1;
                    redir_pc_nxt  = trap_target(kind, mtvec_o, mepc_o, csrfile_mcause_i);
                end
            end

            ST_ISSUE: begin
                state_nxt = ST_IDLE;
            end

            ST_SLEEP: begin
                // Any pending source wakes the core, even when it cannot be taken.
                if (irq_valid) begin
                    if (irq_take) begin
                        state_nxt = ST_DRAIN;
                        flush_nxt = 1'b1;
                        kind_nxt  = KIND_IRQ;
                        cause_nxt = irq_cause;
                        epc_nxt   = commit_pc_i;
                        tval_nxt  = '0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        hold_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            state            <= ST_IDLE;
            kind             <= KIND_EXC;
            csrfile_epc_i    <= '0;
            csrfile_mtval_i  <= '0;
            csrfile_mcause_i <= '0;
            commit_hold_o    <= 1'b0;
            flush_o          <= 1'b0;
            take_exception   <= 1'b0;
            take_interrupt   <= 1'b0;
            mret             <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            state            <= state_nxt;
            kind             <= kind_nxt;
            csrfile_epc_i    <= epc_nxt;
            csrfile_mtval_i  <= tval_nxt;
            csrfile_mcause_i <= cause_nxt;
            commit_hold_o    <= hold_nxt;
            flush_o          <= flush_nxt;
            take_exception   <= take_exc_nxt;
            take_interrupt   <= take_irq_nxt;
            mret             <= mret_nxt;
            redirect_valid_o <= redir_vld_nxt;
            redirect_pc_o    <= redir_pc_nxt;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_trap_ctrl;

    logic        cpu_clock_i = 1'b0;
    logic        cpu_reset_i = 1'b1;
    logic        excp_valid_i = 1'b0;
    logic [3:0]  excp_code_i = '0;
    logic [29:0] excp_pc_i = '0;
    logic [31:0] excp_tval_i = '0;
    logic        mret_valid_i = 1'b0;
    logic        wfi_valid_i = 1'b0;
    logic [29:0] commit_pc_i = '0;
    logic [2:0]  csrfile_mip_o = '0;
    logic        mie_o = 1'b0;
    logic        real_privilege = 1'b1;
    logic [31:0] mtvec_o = 32'h8000_0001;
    logic [29:0] mepc_o = '0;
    logic        flush_done_i = 1'b1;
    logic        commit_hold_o, flush_o;
    logic        take_exception, take_interrupt, mret;
    logic [29:0] csrfile_epc_i;
    logic [31:0] csrfile_mtval_i;
    logic [3:0]  csrfile_mcause_i;
    logic        redirect_valid_o;
    logic [29:0] redirect_pc_o;

    int n_chk = 0;
    int n_pass = 0;

    always #5 cpu_clock_i = ~cpu_clock_i;

    trap_ctrl dut (
        .cpu_clock_i      (cpu_clock_i),
        .cpu_reset_i      (cpu_reset_i),
        .excp_valid_i     (excp_valid_i),
        .excp_code_i      (excp_code_i),
        .excp_pc_i        (excp_pc_i),
        .excp_tval_i      (excp_tval_i),
        .mret_valid_i     (mret_valid_i),
        .wfi_valid_i      (wfi_valid_i),
        .commit_pc_i      (commit_pc_i),
        .csrfile_mip_o    (csrfile_mip_o),
        .mie_o            (mie_o),
        .real_privilege   (real_privilege),
        .mtvec_o          (mtvec_o),
        .mepc_o           (mepc_o),
        .commit_hold_o    (commit_hold_o),
        .flush_o          (flush_o),
        .flush_done_i     (flush_done_i),
        .take_exception   (take_exception),
        .take_interrupt   (take_interrupt),
        .mret             (mret),
        .csrfile_epc_i    (csrfile_epc_i),
        .csrfile_mtval_i  (csrfile_mtval_i),
        .csrfile_mcause_i (csrfile_mcause_i),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // A trap is a record that is opened, waits for the drain, is issued once, then closes.
    logic        m_started = 1'b0;
    logic        m_sleep = 1'b0;
    logic        m_pend = 1'b0;
    logic        m_first = 1'b0;
    logic        m_issue = 1'b0;
    int          m_kind = 0;           // 0 exception, 1 interrupt, 2 return
    logic [3:0]  m_cause = '0;
    logic [29:0] m_epc = '0;
    logic [31:0] m_tval = '0;
    logic [29:0] m_target = '0;

    function automatic logic [3:0] pick_irq(input logic [2:0] m);
        if (m[2]) return 4'd11;
        if (m[0]) return 4'd3;
        if (m[1]) return 4'd7;
        return 4'd0;
    endfunction

    function automatic logic takeable();
        return (csrfile_mip_o != 3'b000) && (mie_o || !real_privilege);
    endfunction

    task automatic open_trap(input int k, input logic [3:0] c, input logic [29:0] e,
                             input logic [31:0] t);
        m_pend  = 1'b1;
        m_first = 1'b1;
        m_kind  = k;
        if (k != 2) begin
            m_cause = c;
            m_epc   = e;
            m_tval  = t;
        end
    endtask

    always @(posedge cpu_clock_i) begin
        longint unsigned sum;
        if (cpu_reset_i) begin
            m_started = 1'b1;
            m_sleep   = 1'b0;
            m_pend    = 1'b0;
            m_first   = 1'b0;
            m_issue   = 1'b0;
        end else begin
            m_first = 1'b0;
            if (m_issue) begin
                m_issue = 1'b0;
                m_pend  = 1'b0;
            end else if (m_pend) begin
                if (flush_done_i) begin
                    m_issue = 1'b1;
                    if (m_kind == 2) m_target = mepc_o;
                    else if (m_kind == 1 && mtvec_o[1:0] == 2'b01) begin
                        sum = longint'(mtvec_o / 4) + longint'(m_cause);
                        m_target = 30'(sum % (64'd1 << 30));
                    end else m_target = 30'(mtvec_o / 4);
                end
            end else if (m_sleep) begin
                if (csrfile_mip_o != 3'b000) begin
                    m_sleep = 1'b0;
                    if (takeable()) open_trap(1, pick_irq(csrfile_mip_o), commit_pc_i, 32'd0);
                end
            end else begin
                if (excp_valid_i) open_trap(0, excp_code_i, excp_pc_i, excp_tval_i);
                else if (takeable()) open_trap(1, pick_irq(csrfile_mip_o), commit_pc_i, 32'd0);
                else if (mret_valid_i) begin
                    if (real_privilege) open_trap(2, 4'd0, 30'd0, 32'd0);
                    else open_trap(0, 4'd2, commit_pc_i, 32'd0);
                end else if (wfi_valid_i) m_sleep = 1'b1;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge cpu_clock_i) begin
        if (m_started) begin
            chk("hold", commit_hold_o, m_pend || m_sleep);
            chk("flush", flush_o, m_first);
            chk("take_exception", take_exception, m_issue && m_kind == 0);
            chk("take_interrupt", take_interrupt, m_issue && m_kind == 1);
            chk("mret", mret, m_issue && m_kind == 2);
            chk("redirect_valid", redirect_valid_o, m_issue);
            chk("redirect_pc", redirect_pc_o, m_issue ? m_target : 30'd0);
            if (m_pend && m_kind != 2) begin
                chk("epc", csrfile_epc_i, m_epc);
                chk("mcause", csrfile_mcause_i, m_cause);
                chk("mtval", csrfile_mtval_i, m_tval);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge cpu_clock_i);
    endtask

    task automatic quiet();
        excp_valid_i  = 1'b0;
        mret_valid_i  = 1'b0;
        wfi_valid_i   = 1'b0;
        csrfile_mip_o = 3'b000;
        flush_done_i  = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hold"}, commit_hold_o, 0);
        chk({tag, "_flush"}, flush_o, 0);
        chk({tag, "_pulses"}, {take_exception, take_interrupt, mret}, 0);
        chk({tag, "_redirect"}, {redirect_valid_o, redirect_pc_o}, 0);
        chk({tag, "_epc"}, csrfile_epc_i, 0);
        chk({tag, "_mtval"}, csrfile_mtval_i, 0);
        chk({tag, "_mcause"}, csrfile_mcause_i, 0);
    endtask

    initial begin
        step();
        step();
        chk_all_zero("reset");
        cpu_reset_i = 1'b0;
        step();

        // Exception with immediate drain.
        mtvec_o = 32'h8000_0001;
        excp_valid_i = 1'b1; excp_code_i = 4'd5; excp_pc_i = 30'h100; excp_tval_i = 32'hDEAD;
        step();
        quiet();
        chk("t1_flush", flush_o, 1);
        chk("t1_epc", csrfile_epc_i, 30'h100);
        step();
        chk("t1_take", take_exception, 1);
        chk("t1_mcause", csrfile_mcause_i, 5);
        chk("t1_mtval", csrfile_mtval_i, 32'hDEAD);
        chk("t1_redir", redirect_pc_o, 30'h2000_0000);
        step();
        chk("t1_hold_drop", commit_hold_o, 0);

        // MSI beats MTI; vectored target.
        mie_o = 1'b1; real_privilege = 1'b1; commit_pc_i = 30'h40; csrfile_mip_o = 3'b011;
        step();
        quiet();
        chk("t2_mcause", csrfile_mcause_i, 3);
        chk("t2_epc", csrfile_epc_i, 30'h40);
        step();
        chk("t2_take", take_interrupt, 1);
        chk("t2_redir", redirect_pc_o, 30'h2000_0003);
        step();

        // Exception and interrupt together: exception first, then the interrupt.
        excp_valid_i = 1'b1; excp_code_i = 4'd1; excp_pc_i = 30'h200; excp_tval_i = 32'h11;
        csrfile_mip_o = 3'b100;
        step();
        excp_valid_i = 1'b0;
        chk("t3_first_cause", csrfile_mcause_i, 1);
        step();
        chk("t3_take_exc", take_exception, 1);
        chk("t3_no_irq", take_interrupt, 0);
        step();
        chk("t3_idle", commit_hold_o, 0);
        step();
        csrfile_mip_o = 3'b000;
        chk("t3_irq_cause", csrfile_mcause_i, 11);
        step();
        chk("t3_take_irq", take_interrupt, 1);
        chk("t3_redir", redirect_pc_o, 30'h2000_000B);
        step();

        // MRET in U-mode becomes an illegal-instruction exception.
        real_privilege = 1'b0; mie_o = 1'b0; mret_valid_i = 1'b1; commit_pc_i = 30'h77;
        step();
        quiet();
        chk("t4_cause", csrfile_mcause_i, 2);
        chk("t4_tval", csrfile_mtval_i, 0);
        step();
        chk("t4_take_exc", take_exception, 1);
        chk("t4_no_mret", mret, 0);
        step();

        // MRET in M-mode.
        real_privilege = 1'b1; mepc_o = 30'h123; mret_valid_i = 1'b1;
        step();
        quiet();
        step();
        chk("t5_mret", mret, 1);
        chk("t5_redir", redirect_pc_o, 30'h123);
        step();

        // WFI, woken by a non-takeable interrupt, then by a takeable one.
        for (int pass = 0; pass < 2; pass++) begin
            mie_o = (pass == 1);
            wfi_valid_i = 1'b1;
            step();
            quiet();
            chk("t6_sleep_hold", commit_hold_o, 1);
            for (int i = 0; i < 10; i++) step();
            chk("t6_still_asleep", commit_hold_o, 1);
            csrfile_mip_o = 3'b010;
            step();
            csrfile_mip_o = 3'b000;
            if (pass == 0) begin
                chk("t6_wake_hold", commit_hold_o, 0);
                chk("t6_wake_flush", flush_o, 0);
            end else begin
                chk("t6_wake_flush_irq", flush_o, 1);
                chk("t6_wake_cause", csrfile_mcause_i, 7);
            end
            step();
            chk("t6_take_irq", take_interrupt, pass == 1);
            step();
        end

        // Reset during a stalled drain aborts the trap.
        flush_done_i = 1'b0;
        excp_valid_i = 1'b1; excp_code_i = 4'd4; excp_tval_i = 32'h55;
        step();
        excp_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t7_no_pulse", take_exception, 0);
        end
        cpu_reset_i = 1'b1;
        step();
        cpu_reset_i = 1'b0;
        flush_done_i = 1'b1;
        chk_all_zero("t7_abort");
        step();

        // Randomized traffic checked by the model.
        for (int i = 0; i < 4000; i++) begin
            cpu_reset_i    = ($urandom_range(0, 299) == 0);
            excp_valid_i   = ($urandom_range(0, 7) == 0);
            excp_code_i    = 4'($urandom);
            excp_pc_i      = 30'($urandom);
            excp_tval_i    = $urandom;
            mret_valid_i   = ($urandom_range(0, 7) == 0);
            wfi_valid_i    = ($urandom_range(0, 5) == 0);
            commit_pc_i    = 30'($urandom);
            csrfile_mip_o  = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
            mie_o          = 1'($urandom);
            real_privilege = ($urandom_range(0, 3) != 0);
            mtvec_o        = {$urandom_range(0, 1) == 1 ? 30'h3FFF_FFF0 + 30'($urandom_range(0, 15))
                                                       : 30'($urandom),
                              ($urandom_range(0, 1) == 1) ? 2'b01 : 2'($urandom)};
            mepc_o         = 30'($urandom);
            flush_done_i   = ($urandom_range(0, 2) != 0);
            step();
        end

        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
